// File: rtl/rv32i_exec_control.sv
// -----------------------------------------------------------------------------
// rv32i_exec_control
// Decode-and-execute core of the single-cycle RV32I CPU. It contains:
//   - the main control decode,
//   - the ALU-operation decode,
//   - the 32-bit ALU with its branch-condition output,
//   - the halt detection, including a sticky registered halt flag.
// Operand selection (rs2 vs. immediate) and immediate generation live outside.
// This block only produces o_alu_src to steer that mux.
//
// Ports
//   i_clk            system clock; only the halt flag is clocked
//   i_reset          asynchronous, active-high; clears the halt flag only
//   i_part_of_inst   current instruction word
//   i_alu_in_1       rs1 value
//   i_alu_in_2       rs2 value or immediate (already muxed outside)
//   i_x17_value      contents of x17 (a7), used for the halt ecall
//   o_is_jal .. o_is_ecall
//                    control decode outputs
//   o_alu_op         decoded ALU operation (ADD=0 .. BGEU=15)
//   o_alu_result     ALU result
//   o_alu_bcond      branch condition true (0 for non-branch ops)
//   o_is_halted      combinational: ecall with x17 == 10
//   o_halted         registered, sticky copy of o_is_halted
// -----------------------------------------------------------------------------
module rv32i_exec_control (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_part_of_inst,
    input  logic [31:0] i_alu_in_1,
    input  logic [31:0] i_alu_in_2,
    input  logic [31:0] i_x17_value,
    output logic        o_is_jal,
    output logic        o_is_jalr,
    output logic        o_branch,
    output logic        o_mem_read,
    output logic        o_mem_to_reg,
    output logic        o_mem_write,
    output logic        o_alu_src,
    output logic        o_reg_write,
    output logic        o_pc_to_reg,
    output logic        o_is_ecall,
    output logic [3:0]  o_alu_op,
    output logic [31:0] o_alu_result,
    output logic        o_alu_bcond,
    output logic        o_is_halted,
    output logic        o_halted
);

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_IARITH = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_ECALL  = 7'b1110011;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_SLL  = 4'd2,  OP_SLT  = 4'd3,
        OP_SLTU = 4'd4,  OP_XOR  = 4'd5,  OP_SRL  = 4'd6,  OP_SRA  = 4'd7,
        OP_OR   = 4'd8,  OP_AND  = 4'd9,  OP_BEQ  = 4'd10, OP_BNE  = 4'd11,
        OP_BLT  = 4'd12, OP_BGE  = 4'd13, OP_BLTU = 4'd14, OP_BGEU = 4'd15
    } alu_op_e;

    logic [6:0]         w_opcode;
    logic [2:0]         w_funct3;
    logic               w_bit30;
    logic               w_unused_inst_bits;
    logic signed [31:0] w_in1_s;
    logic signed [31:0] w_in2_s;
    logic [4:0]         w_shamt;
    logic [31:0]        w_diff;
    logic               w_lt_s;
    logic               w_lt_u;
    logic               w_eq;
    alu_op_e            w_alu_op;
    logic               w_is_halted;
    logic               r_halted;

    assign w_opcode = i_part_of_inst[6:0];
    assign w_funct3 = i_part_of_inst[14:12];
    assign w_bit30  = i_part_of_inst[30];

    // Register indices and immediates are consumed elsewhere in the CPU.
    assign w_unused_inst_bits = &{1'b0, i_part_of_inst[31], i_part_of_inst[29:15],
                                  i_part_of_inst[11:7]};

    assign w_in1_s = $signed(i_alu_in_1);
    assign w_in2_s = $signed(i_alu_in_2);
    assign w_shamt = i_alu_in_2[4:0];
    assign w_diff  = i_alu_in_1 - i_alu_in_2;
    assign w_lt_s  = (w_in1_s < w_in2_s);
    assign w_lt_u  = (i_alu_in_1 < i_alu_in_2);
    assign w_eq    = (i_alu_in_1 == i_alu_in_2);

    // Main control decode; anything not listed leaves every control low.
    always_comb begin
        o_is_jal     = 1'b0;
        o_is_jalr    = 1'b0;
        o_branch     = 1'b0;
        o_mem_read   = 1'b0;
        o_mem_to_reg = 1'b0;
        o_mem_write  = 1'b0;
        o_alu_src    = 1'b0;
        o_reg_write  = 1'b0;
        o_pc_to_reg  = 1'b0;
        o_is_ecall   = 1'b0;
        case (w_opcode)
            OPC_RTYPE:  o_reg_write = 1'b1;
            OPC_IARITH: begin
                o_reg_write = 1'b1;
                o_alu_src   = 1'b1;
            end
            OPC_LOAD: begin
                o_reg_write  = 1'b1;
                o_alu_src    = 1'b1;
                o_mem_read   = 1'b1;
                o_mem_to_reg = 1'b1;
            end
            OPC_STORE: begin
                o_alu_src   = 1'b1;
                o_mem_write = 1'b1;
            end
            OPC_BRANCH: o_branch = 1'b1;
            OPC_JAL: begin
                o_is_jal    = 1'b1;
                o_reg_write = 1'b1;
                o_pc_to_reg = 1'b1;
            end
            OPC_JALR: begin
                o_is_jalr   = 1'b1;
                o_reg_write = 1'b1;
                o_pc_to_reg = 1'b1;
                o_alu_src   = 1'b1;
            end
            OPC_ECALL: o_is_ecall = 1'b1;
            default: ;
        endcase
    end

    // ALU-operation decode. I-arith shares the R-type table, except that
    // funct3 000 ignores bit30 (no SUBI); SRAI/SRLI still use bit30.
    always_comb begin
        w_alu_op = OP_ADD;
        if (w_opcode == OPC_RTYPE || w_opcode == OPC_IARITH) begin
            case (w_funct3)
                3'b000: w_alu_op = (w_opcode == OPC_RTYPE && w_bit30) ? OP_SUB : OP_ADD;
                3'b001: w_alu_op = OP_SLL;
                3'b010: w_alu_op = OP_SLT;
                3'b011: w_alu_op = OP_SLTU;
                3'b100: w_alu_op = OP_XOR;
                3'b101: w_alu_op = w_bit30 ? OP_SRA : OP_SRL;
                3'b110: w_alu_op = OP_OR;
                default: w_alu_op = OP_AND;
            endcase
        end else if (w_opcode == OPC_BRANCH) begin
            case (w_funct3)
                3'b000: w_alu_op = OP_BEQ;
                3'b001: w_alu_op = OP_BNE;
                3'b100: w_alu_op = OP_BLT;
                3'b101: w_alu_op = OP_BGE;
                3'b110: w_alu_op = OP_BLTU;
                3'b111: w_alu_op = OP_BGEU;
                default: w_alu_op = OP_ADD;
            endcase
        end
    end

    assign o_alu_op = w_alu_op;

    // ALU datapath; every branch op reports rs1 - rs2 as its result.
    always_comb begin
        o_alu_result = w_diff;
        o_alu_bcond  = 1'b0;
        case (w_alu_op)
            OP_ADD:  o_alu_result = i_alu_in_1 + i_alu_in_2;
            OP_SUB:  o_alu_result = w_diff;
            OP_SLL:  o_alu_result = i_alu_in_1 << w_shamt;
            OP_SLT:  o_alu_result = {31'd0, w_lt_s};
            OP_SLTU: o_alu_result = {31'd0, w_lt_u};
            OP_XOR:  o_alu_result = i_alu_in_1 ^ i_alu_in_2;
            OP_SRL:  o_alu_result = i_alu_in_1 >> w_shamt;
            OP_SRA:  o_alu_result = $unsigned(w_in1_s >>> w_shamt);
            OP_OR:   o_alu_result = i_alu_in_1 | i_alu_in_2;
            OP_AND:  o_alu_result = i_alu_in_1 & i_alu_in_2;
            OP_BEQ:  o_alu_bcond  = w_eq;
            OP_BNE:  o_alu_bcond  = ~w_eq;
            OP_BLT:  o_alu_bcond  = w_lt_s;
            OP_BGE:  o_alu_bcond  = ~w_lt_s;
            OP_BLTU: o_alu_bcond  = w_lt_u;
            default: o_alu_bcond  = ~w_lt_u;
        endcase
    end

    assign w_is_halted = o_is_ecall && (i_x17_value == 32'd10);
    assign o_is_halted = w_is_halted;

    // Sticky halt: set by a halting ecall, cleared only by reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_halted <= 1'b0;
        else if (w_is_halted)
            r_halted <= 1'b1;
    end

    assign o_halted = r_halted;

endmodule

// File: tb/tb_rv32i_exec_control.sv
// -----------------------------------------------------------------------------
// tb_rv32i_exec_control
// Directed bench for rv32i_exec_control. Each step drives an instruction and
// its operands, then compares the outputs with hand-computed values.
// Control outputs are packed as
//   {jal, jalr, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write,
//    pc_to_reg, ecall}.
// -----------------------------------------------------------------------------
module tb_rv32i_exec_control;

    logic        clk;
    logic        reset;
    logic [31:0] inst;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] x17;
    logic        is_jal, is_jalr, branch, mem_read, mem_to_reg, mem_write;
    logic        alu_src, reg_write, pc_to_reg, is_ecall;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_bcond;
    logic        is_halted;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;

    rv32i_exec_control dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_part_of_inst (inst),
        .i_alu_in_1     (in1),
        .i_alu_in_2     (in2),
        .i_x17_value    (x17),
        .o_is_jal       (is_jal),
        .o_is_jalr      (is_jalr),
        .o_branch       (branch),
        .o_mem_read     (mem_read),
        .o_mem_to_reg   (mem_to_reg),
        .o_mem_write    (mem_write),
        .o_alu_src      (alu_src),
        .o_reg_write    (reg_write),
        .o_pc_to_reg    (pc_to_reg),
        .o_is_ecall     (is_ecall),
        .o_alu_op       (alu_op),
        .o_alu_result   (alu_result),
        .o_alu_bcond    (alu_bcond),
        .o_is_halted    (is_halted),
        .o_halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] ctrl_vec();
        return {is_jal, is_jalr, branch, mem_read, mem_to_reg, mem_write,
                alu_src, reg_write, pc_to_reg, is_ecall};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        inst = i;
        in1  = a;
        in2  = b;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        inst  = 32'h0000_0013;
        in1   = 32'd0;
        in2   = 32'd0;
        x17   = 32'd0;
        #2;
        check("reset_halted", {31'd0, halted}, 32'd0);

        // ADD with reset still asserted: combinational outputs are independent of reset
        apply(32'h0020_81B3, 32'd5, 32'd7);
        check("add_op",     {28'd0, alu_op}, 32'd0);
        check("add_result", alu_result, 32'd12);
        check("add_ctrl",   {22'd0, ctrl_vec()}, 32'b00_0000_0100);
        check("add_bcond",  {31'd0, alu_bcond}, 32'd0);
        #2;
        reset = 1'b0;

        apply(32'h4020_81B3, 32'd5, 32'd7);
        check("sub_op",     {28'd0, alu_op}, 32'd1);
        check("sub_result", alu_result, 32'hFFFF_FFFE);

        apply(32'h4040_D193, 32'h8000_0000, 32'd4);
        check("srai_op",     {28'd0, alu_op}, 32'd7);
        check("srai_result", alu_result, 32'hF800_0000);
        check("srai_ctrl",   {22'd0, ctrl_vec()}, 32'b00_0000_1100);
        apply(32'h0040_D193, 32'h8000_0000, 32'd4);
        check("srli_result", alu_result, 32'h0800_0000);

        // ADDI with bit30 set must stay ADD
        apply(32'h4000_8193, 32'd5, 32'd7);
        check("addi_b30_op",     {28'd0, alu_op}, 32'd0);
        check("addi_b30_result", alu_result, 32'd12);

        apply(32'h0020_A1B3, 32'hFFFF_FFFF, 32'd1);
        check("slt_result", alu_result, 32'd1);
        apply(32'h0020_B1B3, 32'hFFFF_FFFF, 32'd1);
        check("sltu_result", alu_result, 32'd0);

        // Shift amount uses only the low five bits (0x23 -> 3)
        apply(32'h0020_91B3, 32'd1, 32'h0000_0023);
        check("sll_result", alu_result, 32'd8);
        apply(32'h0020_C1B3, 32'h0000_F0F0, 32'h0000_FF00);
        check("xor_result", alu_result, 32'h0000_0FF0);
        apply(32'h0020_E1B3, 32'h0000_F0F0, 32'h0000_FF00);
        check("or_result", alu_result, 32'h0000_FFF0);
        apply(32'h0020_F1B3, 32'h0000_F0F0, 32'h0000_FF00);
        check("and_result", alu_result, 32'h0000_F000);

        // Branches
        apply(32'h0020_C063, 32'hFFFF_FFFF, 32'd1);
        check("blt_bcond",  {31'd0, alu_bcond}, 32'd1);
        check("blt_ctrl",   {22'd0, ctrl_vec()}, 32'b00_1000_0000);
        check("blt_op",     {28'd0, alu_op}, 32'd12);
        check("blt_result", alu_result, 32'hFFFF_FFFE);
        apply(32'h0020_E063, 32'hFFFF_FFFF, 32'd1);
        check("bltu_bcond", {31'd0, alu_bcond}, 32'd0);
        apply(32'h0020_D063, 32'hFFFF_FFFF, 32'd1);
        check("bge_bcond", {31'd0, alu_bcond}, 32'd0);
        apply(32'h0020_F063, 32'hFFFF_FFFF, 32'd1);
        check("bgeu_bcond", {31'd0, alu_bcond}, 32'd1);
        apply(32'h0020_8063, 32'd3, 32'd3);
        check("beq_bcond",  {31'd0, alu_bcond}, 32'd1);
        check("beq_result", alu_result, 32'd0);
        apply(32'h0020_9063, 32'd3, 32'd3);
        check("bne_bcond", {31'd0, alu_bcond}, 32'd0);
        apply(32'h0020_A063, 32'd3, 32'd3);
        check("br_f010_op",    {28'd0, alu_op}, 32'd0);
        check("br_f010_bcond", {31'd0, alu_bcond}, 32'd0);
        check("br_f010_res",   alu_result, 32'd6);

        // Memory, jumps, unknown opcode
        apply(32'h0000_A183, 32'h0000_1000, 32'd4);
        check("lw_ctrl",   {22'd0, ctrl_vec()}, 32'b00_0110_1100);
        check("lw_result", alu_result, 32'h0000_1004);
        apply(32'h0020_A023, 32'h0000_1000, 32'd8);
        check("sw_ctrl", {22'd0, ctrl_vec()}, 32'b00_0001_1000);
        apply(32'h0001_00E7, 32'h0000_2001, 32'd0);
        check("jalr_ctrl",   {22'd0, ctrl_vec()}, 32'b01_0000_1110);
        check("jalr_result", alu_result, 32'h0000_2001);
        apply(32'h0000_00EF, 32'd0, 32'd0);
        check("jal_ctrl", {22'd0, ctrl_vec()}, 32'b10_0000_0110);
        apply(32'h0000_007F, 32'd5, 32'd7);
        check("unk_ctrl", {22'd0, ctrl_vec()}, 32'd0);
        check("unk_op",   {28'd0, alu_op}, 32'd0);

        // ECALL without halt request
        x17 = 32'd9;
        apply(32'h0000_0073, 32'd0, 32'd0);
        check("ecall_ctrl",     {22'd0, ctrl_vec()}, 32'b00_0000_0001);
        check("ecall9_ishalt",  {31'd0, is_halted}, 32'd0);
        @(posedge clk); #1;
        check("ecall9_halted",  {31'd0, halted}, 32'd0);

        // Halt with reset held: reset wins over the edge
        reset = 1'b1;
        x17   = 32'd10;
        #1;
        check("ecall10_ishalt", {31'd0, is_halted}, 32'd1);
        @(posedge clk); #1;
        check("rst_wins_halted", {31'd0, halted}, 32'd0);
        reset = 1'b0;
        #1;
        check("pre_edge_halted", {31'd0, halted}, 32'd0);
        @(posedge clk); #1;
        check("halted_set", {31'd0, halted}, 32'd1);

        // Sticky after the instruction changes
        x17 = 32'd0;
        apply(32'h0020_81B3, 32'd5, 32'd7);
        check("post_ishalt", {31'd0, is_halted}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("halted_sticky", {31'd0, halted}, 32'd1);

        // Asynchronous clear mid-cycle
        #2;
        reset = 1'b1;
        #1;
        check("async_clear", {31'd0, halted}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("after_clear", {31'd0, halted}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
